// File: rtl/sample_send_ctrl_if.sv
// Handshake bundle between sample_send_ctrl and its neighbours: main FSM start/count,
// sample RAM read port and the uart_tx byte handshake. slave = controller side.
interface sample_send_ctrl_if #(
  parameter int ADDR_WIDTH   = 8,
  parameter int SAMPLE_BYTES = 2
);
  logic                      iStartSending;
  logic [ADDR_WIDTH:0]       iNumSamples;
  logic                      oMemRdEn;
  logic [ADDR_WIDTH-1:0]     oMemAddr;
  logic [8*SAMPLE_BYTES-1:0] iMemData;
  logic                      oTxStart;
  logic [7:0]                oTxData;
  logic                      iTxDone;
  logic                      oBusy;
  logic                      oSendingDone;

  modport slave (
    input  iStartSending, iNumSamples, iMemData, iTxDone,
    output oMemRdEn, oMemAddr, oTxStart, oTxData, oBusy, oSendingDone
  );

  modport master (
    output iStartSending, iNumSamples, iMemData, iTxDone,
    input  oMemRdEn, oMemAddr, oTxStart, oTxData, oBusy, oSendingDone
  );
endinterface

// File: rtl/sample_send_ctrl.sv
// Streams N sample words from RAM to uart_tx, MSB byte first, one byte per handshake.
// Define SEND_CHECKSUM_EN to append an XOR checksum byte after the last data byte.
module sample_send_ctrl #(
  parameter int ADDR_WIDTH   = 8,
  parameter int SAMPLE_BYTES = 2
) (
  input  logic              iClock,
  input  logic              iReset,
  sample_send_ctrl_if.slave bus
);
  localparam int SW = 8 * SAMPLE_BYTES;
  localparam logic [1:0]            LAST_BYTE = 2'(SAMPLE_BYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   NUM_ONE   = (ADDR_WIDTH + 1)'(1);

  typedef enum logic [2:0] {
    IDLE,
    READ,
    LATCH,
    SEND,
    WAIT,
`ifdef SEND_CHECKSUM_EN
    CKSUM,
`endif
    DONE
  } state_t;

`ifdef SEND_CHECKSUM_EN
  localparam state_t AFTER_DATA = CKSUM;
`else
  localparam state_t AFTER_DATA = DONE;
`endif

  state_t                state;
  logic [SW-1:0]         shiftReg;
  logic [1:0]            byteIdx;
  logic [ADDR_WIDTH-1:0] lastAddr;
  logic                  inTrailer;

`ifdef SEND_CHECKSUM_EN
  logic [7:0] xorReg;
  logic       cksumPhase;
  assign inTrailer = cksumPhase;
`else
  assign inTrailer = 1'b0;
`endif

  function automatic logic [7:0] topByte(input logic [SW-1:0] word);
    return word[SW-1 -: 8];
  endfunction

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state            <= IDLE;
      bus.oMemRdEn     <= 1'b0;
      bus.oMemAddr     <= '0;
      bus.oTxStart     <= 1'b0;
      bus.oTxData      <= '0;
      bus.oBusy        <= 1'b0;
      bus.oSendingDone <= 1'b0;
      shiftReg         <= '0;
      byteIdx          <= '0;
      lastAddr         <= '0;
`ifdef SEND_CHECKSUM_EN
      xorReg           <= '0;
      cksumPhase       <= 1'b0;
`endif
    end else begin
      bus.oMemRdEn     <= 1'b0;
      bus.oTxStart     <= 1'b0;
      bus.oSendingDone <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStartSending) begin
            bus.oBusy    <= 1'b1;
            bus.oMemAddr <= '0;
            // The count is only needed as the final address, so keep N-1.
            lastAddr     <= ADDR_WIDTH'(bus.iNumSamples - NUM_ONE);
`ifdef SEND_CHECKSUM_EN
            xorReg       <= '0;
            cksumPhase   <= 1'b0;
`endif
            if (bus.iNumSamples == '0) begin
              state <= AFTER_DATA;
            end else begin
              state        <= READ;
              bus.oMemRdEn <= 1'b1;
            end
          end
        end
        READ: state <= LATCH;
        LATCH: begin
          // First byte goes out straight from the RAM word; the rest queue in shiftReg.
          shiftReg     <= bus.iMemData << 8;
          byteIdx      <= '0;
          bus.oTxData  <= topByte(bus.iMemData);
          bus.oTxStart <= 1'b1;
`ifdef SEND_CHECKSUM_EN
          xorReg       <= xorReg ^ topByte(bus.iMemData);
`endif
          state        <= SEND;
        end
        SEND: state <= WAIT;
        WAIT: begin
          if (bus.iTxDone) begin
            if (inTrailer) begin
              state <= DONE;
            end else if (byteIdx != LAST_BYTE) begin
              byteIdx      <= byteIdx + 2'd1;
              shiftReg     <= shiftReg << 8;
              bus.oTxData  <= topByte(shiftReg);
              bus.oTxStart <= 1'b1;
`ifdef SEND_CHECKSUM_EN
              xorReg       <= xorReg ^ topByte(shiftReg);
`endif
              state        <= SEND;
            end else if (bus.oMemAddr != lastAddr) begin
              bus.oMemAddr <= bus.oMemAddr + ADDR_ONE;
              bus.oMemRdEn <= 1'b1;
              state        <= READ;
            end else begin
              state <= AFTER_DATA;
            end
          end
        end
`ifdef SEND_CHECKSUM_EN
        CKSUM: begin
          bus.oTxData  <= xorReg;
          bus.oTxStart <= 1'b1;
          cksumPhase   <= 1'b1;
          state        <= SEND;
        end
`endif
        DONE: begin
          bus.oSendingDone <= 1'b1;
          bus.oBusy        <= 1'b0;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_send_ctrl.sv
// Bench for sample_send_ctrl: table vectors, corner sequences and randomized transfers
// against a byte/cycle reference model; RAM and uart_tx are behavioural models.
module tb_sample_send_ctrl;
  localparam int AW    = 4;
  localparam int SB    = 2;
  localparam int DEPTH = 1 << AW;

  typedef logic [AW:0] num_t;
  typedef struct {
    int          n;
    logic [15:0] w0;
    logic [15:0] w1;
    int          dly;
    int          nBytes;
    logic [39:0] bytes;
    int          doneLat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sample_send_ctrl_if #(.ADDR_WIDTH(AW), .SAMPLE_BYTES(SB)) ifc();
  sample_send_ctrl #(.ADDR_WIDTH(AW), .SAMPLE_BYTES(SB)) dut (
    .iClock(clk),
    .iReset(rst),
    .bus   (ifc)
  );

  logic [15:0] ram [DEPTH];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   txDelay = 1;
  bit   spurMode = 1'b0;
  logic [7:0] txBytes[$];
  int   txCycles[$];
  int   rdAddrs[$];
  int   doneCycles[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Event log, sampled mid-cycle.
  always @(negedge clk) begin
    if (ifc.oTxStart) begin
      txBytes.push_back(ifc.oTxData);
      txCycles.push_back(cyc);
    end
    if (ifc.oMemRdEn) rdAddrs.push_back(int'(ifc.oMemAddr));
    if (ifc.oSendingDone) doneCycles.push_back(cyc);
  end

  // uart_tx model: done pulse txDelay cycles after each start; optional spurious pulses.
  initial begin
    int cnt;
    bit fire;
    cnt = 0;
    ifc.iTxDone = 1'b0;
    forever begin
      @(negedge clk);
      fire = 1'b0;
      if (rst) cnt = 0;
      else begin
        if (cnt > 0) begin
          cnt--;
          fire = (cnt == 0);
        end
        if (ifc.oTxStart) cnt = txDelay;
      end
      ifc.iTxDone = fire || (spurMode && !rst && (ifc.oTxStart || ifc.oMemRdEn || !ifc.oBusy));
    end
  end

  // Sync RAM model: data valid the cycle after a read, garbage otherwise.
  initial begin
    bit rd;
    int a;
    ifc.iMemData = '0;
    forever begin
      @(negedge clk);
      rd = ifc.oMemRdEn;
      a  = int'(ifc.oMemAddr);
      @(posedge clk);
      #1;
      ifc.iMemData = rd ? ram[a] : 16'($urandom);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkIdle(input string name);
    chk({name, " oBusy"}, 32'(ifc.oBusy), 0);
    chk({name, " oMemRdEn"}, 32'(ifc.oMemRdEn), 0);
    chk({name, " oMemAddr"}, 32'(ifc.oMemAddr), 0);
    chk({name, " oTxStart"}, 32'(ifc.oTxStart), 0);
    chk({name, " oTxData"}, 32'(ifc.oTxData), 0);
    chk({name, " oSendingDone"}, 32'(ifc.oSendingDone), 0);
  endtask

  task automatic clearLogs();
    txBytes.delete();
    txCycles.delete();
    rdAddrs.delete();
    doneCycles.delete();
  endtask

  task automatic startXfer(input int n, output int t);
    @(negedge clk);
    ifc.iNumSamples   = num_t'(n);
    ifc.iStartSending = 1'b1;
    t = cyc;
    @(negedge clk);
    ifc.iStartSending = 1'b0;
    ifc.iNumSamples   = num_t'($urandom);
  endtask

  task automatic waitDone(input string name, input int budget);
    int k;
    k = 0;
    while (doneCycles.size() == 0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (doneCycles.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s timeout: no oSendingDone within %0d cycles", name, budget);
    end
    repeat (4) @(negedge clk);
  endtask

  // Reference: expected bytes, start cycles, addresses and done cycle from the protocol rules.
  task automatic checkModel(input string name, input int n, input int d, input int t);
    logic [7:0] expB[$];
    int         expC[$];
    logic [7:0] x, v;
    int         s, doneAt;
    x = '0;
    s = t;
    for (int i = 0; i < n; i++) begin
      for (int b = 0; b < SB; b++) begin
        v = ram[i][8*(SB-1-b) +: 8];
        if (i == 0 && b == 0) s = t + 3;
        else if (b == 0)      s = s + d + 3;
        else                  s = s + d + 1;
        expB.push_back(v);
        expC.push_back(s);
        x ^= v;
      end
    end
`ifdef SEND_CHECKSUM_EN
    s = (n == 0) ? t + 2 : s + d + 2;
    expB.push_back(x);
    expC.push_back(s);
    doneAt = s + d + 2;
`else
    doneAt = (n == 0) ? t + 2 : s + d + 2;
`endif
    chk({name, " byte count"}, txBytes.size(), expB.size());
    for (int i = 0; i < expB.size() && i < txBytes.size(); i++) begin
      chk($sformatf("%s byte%0d", name, i), 32'(txBytes[i]), 32'(expB[i]));
      chk($sformatf("%s start%0d cycle", name, i), txCycles[i] - t, expC[i] - t);
    end
    chk({name, " read count"}, rdAddrs.size(), n);
    for (int i = 0; i < n && i < rdAddrs.size(); i++)
      chk($sformatf("%s addr%0d", name, i), rdAddrs[i], i);
    chk({name, " done pulses"}, doneCycles.size(), 1);
    if (doneCycles.size() > 0) chk({name, " done cycle"}, doneCycles[0] - t, doneAt - t);
  endtask

  initial begin
    vec_t       tbl[4];
    int         t, k;
    logic [39:0] pk;
    string      nm;

`ifdef SEND_CHECKSUM_EN
    tbl[0] = '{2, 16'h1234, 16'hABCD, 10, 5, 40'h1234ABCD40, 62};
    tbl[1] = '{0, 16'h0000, 16'h0000,  3, 1, 40'h00,          7};
    tbl[2] = '{1, 16'h00FF, 16'h5555,  1, 3, 40'h00FFFF,     11};
    tbl[3] = '{1, 16'h8001, 16'h5555,  4, 3, 40'h800181,     20};
`else
    tbl[0] = '{2, 16'h1234, 16'hABCD, 10, 4, 40'h1234ABCD,   50};
    tbl[1] = '{0, 16'h0000, 16'h0000,  3, 0, 40'h0,           2};
    tbl[2] = '{1, 16'h00FF, 16'h5555,  1, 2, 40'h00FF,        8};
    tbl[3] = '{1, 16'h8001, 16'h5555,  4, 2, 40'h8001,       14};
`endif

    rst = 1'b1;
    ifc.iStartSending = 1'b0;
    ifc.iNumSamples   = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 16'($urandom);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checkIdle("reset");

    // Table vectors.
    for (int v = 0; v < 4; v++) begin
      nm = $sformatf("vec%0d", v);
      ram[0]  = tbl[v].w0;
      ram[1]  = tbl[v].w1;
      txDelay = tbl[v].dly;
      clearLogs();
      startXfer(tbl[v].n, t);
      waitDone(nm, 400);
      pk = tbl[v].bytes;
      chk({nm, " byte count"}, txBytes.size(), tbl[v].nBytes);
      for (int i = 0; i < tbl[v].nBytes && i < txBytes.size(); i++)
        chk($sformatf("%s byte%0d", nm, i), 32'(txBytes[i]), 32'(pk[8*(tbl[v].nBytes-1-i) +: 8]));
      chk({nm, " reads"}, rdAddrs.size(), tbl[v].n);
      chk({nm, " done pulses"}, doneCycles.size(), 1);
      if (doneCycles.size() > 0) chk({nm, " done latency"}, doneCycles[0] - t, tbl[v].doneLat);
    end

    // Full RAM: every address once, no wrap.
    for (int i = 0; i < DEPTH; i++) ram[i] = 16'($urandom);
    txDelay = 2;
    clearLogs();
    startXfer(DEPTH, t);
    waitDone("fullram", 2000);
    checkModel("fullram", DEPTH, 2, t);

    // Asynchronous reset while waiting on the third byte, then a clean restart.
    ram[0]  = 16'h1234;
    ram[1]  = 16'hABCD;
    txDelay = 10;
    clearLogs();
    startXfer(2, t);
    k = 0;
    while (txBytes.size() < 3 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("abort reached byte3", txBytes.size(), 3);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 checkIdle("async reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("abort done pulses", doneCycles.size(), 0);
    clearLogs();
    startXfer(2, t);
    waitDone("restart", 400);
    checkModel("restart", 2, 10, t);

    // Re-pulsed start and spurious iTxDone must not disturb the transfer.
    spurMode = 1'b1;
    clearLogs();
    startXfer(2, t);
    for (int j = 0; j < 80 && doneCycles.size() == 0; j++) begin
      @(negedge clk);
      ifc.iStartSending = (j == 4 || j == 20 || j == 40);
    end
    ifc.iStartSending = 1'b0;
    waitDone("spurious", 300);
    checkModel("spurious", 2, 10, t);
    spurMode = 1'b0;

    // Randomized transfers.
    for (int r = 0; r < 6; r++) begin
      int n, d;
      for (int i = 0; i < DEPTH; i++) ram[i] = 16'($urandom);
      n        = $urandom_range(0, DEPTH);
      d        = $urandom_range(1, 5);
      txDelay  = d;
      spurMode = ($urandom_range(0, 1) == 1);
      nm = $sformatf("rand%0d", r);
      clearLogs();
      startXfer(n, t);
      waitDone(nm, 3000);
      checkModel(nm, n, d, t);
    end
    spurMode = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, %0d vectors so far", vectors);
    $fatal(1, "watchdog");
  end
endmodule
